mem_lock_responder: RTL and testbench
=====================================

# mem_lock_responder

Responder side of the per-SIC memory lock/access protocol. It arbitrates read/write lock requests from all single-instruction controllers, grants exclusive ownership to the oldest requester by issue ID, and holds the grant until that SIC's release pulse. It serves combinational reads and performs committed writes on a word-addressed data memory. It sits between the SIC array and data storage, in place of a bare memory.

## Interface
- `NUM_SICS`, default 4: number of requesting SIC ports.
- `ID_WIDTH`, default 4: issue-ID width; IDs wrap modulo 2^ID_WIDTH.
- `MEM_WORDS`, default 1024: memory depth in 32-bit words; power of two.

Ports (per-SIC ports are unpacked arrays `[NUM_SICS]`):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `head_issue_id`  in  ID_WIDTH  oldest in-flight issue ID; reference point for age comparison.
- `mem_req_read[i]`  in  1  SIC i requests the lock for a load.
- `mem_req_write[i]`  in  1  SIC i requests the lock for a store.
- `mem_issue_id[i]`  in  ID_WIDTH  issue ID of SIC i's instruction.
- `mem_addr[i]`  in  32  byte address.
- `mem_wdata[i]`  in  32  store data.
- `mem_write_commit[i]`  in  1  single-cycle store commit.
- `mem_release[i]`  in  1  single-cycle lock release; also used for abort.
- `mem_grant[i]`  out  1  SIC i holds the lock.
- `mem_rdata[i]`  out  32  read data for SIC i.
- `holder_valid`  out  1  some SIC holds the lock.
- `holder_idx`  out  $clog2(NUM_SICS)  index of the current holder.
- `protocol_err`  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, HELD.
- Reset: state IDLE; all outputs 0 (`mem_grant`, `mem_rdata`, `holder_valid`, `holder_idx`, `protocol_err`). Memory contents are not cleared.
- Requesting: SIC i is requesting when `mem_req_read[i] | mem_req_write[i]`.
- Age: `(mem_issue_id[i] - head_issue_id) mod 2^ID_WIDTH`. Smaller is older.
- Winner: the requester with the smallest age. On equal ages, the lowest index wins.
- IDLE with at least one requester:
  - Latch the winner into `holder_idx`.
  - Go to HELD.
  - `mem_grant[winner]` and `holder_valid` rise on the next cycle.
- IDLE with no requesters: stay in IDLE.
- HELD: the grant is held regardless of the holder's request lines. The SIC drops its requests before its release pulse.
- HELD, `mem_release[holder_idx]` = 1: go to IDLE; grant and `holder_valid` fall on the next cycle. No write occurs unless a commit was seen earlier, so a release without a commit is a clean abort.
- Read data: `mem_rdata[holder_idx] = mem[mem_addr[holder_idx][$clog2(MEM_WORDS)+1:2]]`, combinational, valid whenever held. Non-holders read 0. Upper address bits are ignored (aliasing wrap).
- Write: happens at the edge where HELD, `mem_write_commit[holder_idx]` = 1 and `mem_addr[1:0]` = 0. Read data reflects the new value from the next cycle.
- Set `protocol_err`, with no other effect, on any of:
  - `mem_write_commit` or `mem_release` from a non-holder;
  - a misaligned commit (the write is dropped);
  - commit and release from the holder in the same cycle (the commit is still performed, then released).
- `protocol_err` clears only on `rst`.
- Requests from non-holders stay pending. No grant is queued; arbitration is re-evaluated each IDLE cycle.

## Timing
- Grant latency: request seen in IDLE at edge N → `mem_grant` high during cycle N+1.
- Release: release at edge M → grant low in cycle M+1. Earliest new grant is cycle M+2 (one IDLE cycle between holders).
- Reads: zero latency. Writes: one edge.
- `rst` asserted mid-HELD: grant and `holder_valid` drop asynchronously; pending commits are lost. After `rst` deasserts, the first edge is an IDLE arbitration.
- Age arithmetic is ID_WIDTH-bit unsigned subtraction with wrap. Issue IDs that are older than `head_issue_id` alias as youngest; correct issue control never produces them.

## Test plan
- Basic store then load:
  - SIC0 request write (id 2, head 0): grant in cycle 1.
  - Commit addr 0x10, data 0xDEADBEEF, then release.
  - SIC1 request read: granted 2 cycles after release; `mem_rdata[1]` = 0xDEADBEEF.
- Age order with wrap: head=14, SIC0 id=1, SIC1 id=15, both request in the same cycle → SIC1 granted first. SIC0 granted two cycles after SIC1's release.
- Abort: holder releases without committing → memory at its address is unchanged; `protocol_err` stays 0.
- Violations, each setting `protocol_err` = 1 with memory unchanged:
  - non-holder commit;
  - misaligned commit addr 0x12;
  - non-holder release (grant also unaffected).
- Reset mid-hold: assert `rst` while SIC2 holds → grant 0 immediately; after deassert, the still-requesting SIC2 is re-granted within 2 cycles.
- Tie and read isolation: SIC1 and SIC3 request with equal ids → SIC1 granted; `mem_rdata[3]` = 0 throughout.

Source files
------------

// File: rtl/mem_lock_responder.sv
// Lock responder: arbitrates SIC lock requests oldest-issue-ID first and fronts a word-addressed data memory.
// Latency: grant one edge after a request in IDLE; reads combinational; a committed store lands at the next edge.
// Backpressure: losing requesters simply keep requesting; nothing is queued, arbitration reruns every IDLE cycle.
module mem_lock_responder #(
    parameter int NUM_SICS  = 4,
    parameter int ID_WIDTH  = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ID_WIDTH-1:0]         head_issue_id,
    input  logic                        mem_req_read     [NUM_SICS],
    input  logic                        mem_req_write    [NUM_SICS],
    input  logic [ID_WIDTH-1:0]         mem_issue_id     [NUM_SICS],
    input  logic [31:0]                 mem_addr         [NUM_SICS],
    input  logic [31:0]                 mem_wdata        [NUM_SICS],
    input  logic                        mem_write_commit [NUM_SICS],
    input  logic                        mem_release      [NUM_SICS],
    output logic                        mem_grant        [NUM_SICS],
    output logic [31:0]                 mem_rdata        [NUM_SICS],
    output logic                        holder_valid,
    output logic [$clog2(NUM_SICS)-1:0] holder_idx,
    output logic                        protocol_err
);
    localparam int IDX_W = $clog2(NUM_SICS);
    localparam int AW    = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, HELD} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  holder_n;
    logic [IDX_W-1:0]  win_idx;
    logic              win_vld;
    logic [ID_WIDTH-1:0] age;
    logic [ID_WIDTH-1:0] win_age;
    logic              err_n;
    logic              wr_en;
    logic              foreign_ctl;
    logic [AW-1:0]     hold_word;
    logic              unused_addr_bits;
    logic [31:0]       mem [MEM_WORDS];

    // Age is distance from the head ID with wrap; strict compare keeps the lowest index on ties.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_age = '1;
        age     = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            age = mem_issue_id[i] - head_issue_id;
            if ((mem_req_read[i] || mem_req_write[i]) && (!win_vld || age < win_age)) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                win_age = age;
            end
        end
    end

    assign hold_word = mem_addr[holder_idx][AW+1:2];

    always_comb begin
        state_n     = state;
        holder_n    = holder_idx;
        err_n       = protocol_err;
        wr_en       = 1'b0;
        foreign_ctl = 1'b0;
        for (int i = 0; i < NUM_SICS; i++) begin
            if (state != HELD || holder_idx != IDX_W'(i)) begin
                foreign_ctl = foreign_ctl | mem_write_commit[i] | mem_release[i];
            end
        end
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_n  = HELD;
                    holder_n = win_idx;
                end
            end
            HELD: begin
                if (mem_write_commit[holder_idx]) begin
                    if (mem_addr[holder_idx][1:0] == 2'b00) begin
                        wr_en = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                // Commit alongside release is still honoured, but flagged.
                if (mem_release[holder_idx]) begin
                    state_n = IDLE;
                    if (mem_write_commit[holder_idx]) begin
                        err_n = 1'b1;
                    end
                end
            end
        endcase
        if (foreign_ctl) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            holder_idx   <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_n;
            holder_idx   <= holder_n;
            protocol_err <= err_n;
        end
    end

    // Storage contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[hold_word] <= mem_wdata[holder_idx];
        end
    end

    assign holder_valid = (state == HELD);

    always_comb begin
        for (int i = 0; i < NUM_SICS; i++) begin
            mem_grant[i] = (state == HELD) && (holder_idx == IDX_W'(i));
            mem_rdata[i] = mem_grant[i] ? mem[hold_word] : '0;
        end
    end

    // Address bits above the memory depth alias by design.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NUM_SICS; i++) begin
            unused_addr_bits = unused_addr_bits ^ (^mem_addr[i][31:AW+2]);
        end
    end

endmodule

// File: tb/tb_mem_lock_responder.sv
// Bench for mem_lock_responder: per-cycle expected snapshots from a reference model, checked by a separate monitor.
`timescale 1ns/1ps
module tb_mem_lock_responder;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int MW = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] head_issue_id;
    logic          mem_req_read     [N];
    logic          mem_req_write    [N];
    logic [IW-1:0] mem_issue_id     [N];
    logic [31:0]   mem_addr         [N];
    logic [31:0]   mem_wdata        [N];
    logic          mem_write_commit [N];
    logic          mem_release      [N];
    logic          mem_grant        [N];
    logic [31:0]   mem_rdata        [N];
    logic          holder_valid;
    logic [1:0]    holder_idx;
    logic          protocol_err;

    mem_lock_responder #(.NUM_SICS(N), .ID_WIDTH(IW), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .head_issue_id(head_issue_id),
        .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
        .mem_issue_id(mem_issue_id), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write_commit(mem_write_commit), .mem_release(mem_release),
        .mem_grant(mem_grant), .mem_rdata(mem_rdata), .holder_valid(holder_valid),
        .holder_idx(holder_idx), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int        cyc;
        bit        in_rst;
        bit        hv;
        int        idx;
        bit        err;
        bit        chk;
        bit [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: who holds the lock, sticky error, and the memory words we know.
    bit        m_held = 0;
    int        m_h = 0;
    bit        m_err = 0;
    bit [31:0] m_mem   [MW];
    bit        m_known [MW];
    int        hold_ph = 0;
    int        plan = 0;

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] gv, gexp;
        logic [31:0] hrd;
        bit         nz, bad;
        if (q.size() != 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            vectors++;
            gv = '0; gexp = '0; hrd = '0; nz = 0;
            for (int i = 0; i < N; i++) begin
                gv[i] = mem_grant[i];
                if (e.hv && e.idx == i) hrd = mem_rdata[i];
                else if (mem_rdata[i] !== 32'h0) nz = 1;
            end
            if (e.hv) gexp[e.idx] = 1'b1;
            bad = (holder_valid !== e.hv) || (gv !== gexp) || (protocol_err !== e.err) || nz
                  || (e.hv && holder_idx !== 2'(e.idx)) || (e.in_rst && holder_idx !== 2'd0)
                  || (e.hv && e.chk && hrd !== e.rd);
            if (bad) begin
                miscompares++;
                $display("FAIL cycle %0d snapshot: got hv=%b idx=%0d grant=%b err=%b rdata=%h stray_rdata=%b; want hv=%b idx=%0d grant=%b err=%b rdata=%h(chk=%b)",
                         cyc, holder_valid, holder_idx, gv, protocol_err, hrd, nz,
                         e.hv, e.idx, gexp, e.err, e.rd, e.chk);
            end
        end
    end

    // Record what this cycle must show, advance the model across the coming edge, then step.
    task automatic tick();
        exp_t e;
        int   best, bage, age, w;
        e.cyc = cyc; e.in_rst = rst; e.hv = m_held && !rst; e.idx = m_h;
        e.err = m_err && !rst; e.chk = 0; e.rd = '0;
        if (e.hv) begin
            w = int'(mem_addr[m_h] >> 2) % MW;
            e.chk = m_known[w];
            e.rd  = m_mem[w];
        end
        q.push_back(e);
        if (rst) begin
            m_held = 0; m_err = 0;
        end else if (!m_held) begin
            best = -1; bage = 0;
            for (int i = 0; i < N; i++) begin
                if (mem_req_read[i] || mem_req_write[i]) begin
                    age = (int'(mem_issue_id[i]) - int'(head_issue_id) + 16) % 16;
                    if (best < 0 || age < bage) begin best = i; bage = age; end
                end
                if (mem_write_commit[i] || mem_release[i]) m_err = 1;
            end
            if (best >= 0) begin m_held = 1; m_h = best; end
        end else begin
            for (int i = 0; i < N; i++)
                if (i != m_h && (mem_write_commit[i] || mem_release[i])) m_err = 1;
            if (mem_write_commit[m_h]) begin
                if (mem_addr[m_h][1:0] != 2'b00) m_err = 1;
                else begin
                    w = int'(mem_addr[m_h] >> 2) % MW;
                    m_mem[w] = mem_wdata[m_h];
                    m_known[w] = 1;
                end
            end
            if (mem_release[m_h]) begin
                if (mem_write_commit[m_h]) m_err = 1;
                m_held = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < N; i++) begin
            mem_write_commit[i] = 1'b0;
            mem_release[i] = 1'b0;
        end
    endtask

    task automatic clr_all();
        clr_pulses();
        for (int i = 0; i < N; i++) begin
            mem_req_read[i] = 1'b0; mem_req_write[i] = 1'b0;
            mem_issue_id[i] = '0; mem_addr[i] = '0; mem_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        clr_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic request(int i, bit wr, int id, logic [31:0] a);
        mem_req_read[i]  = !wr;
        mem_req_write[i] = wr;
        mem_issue_id[i]  = IW'(id);
        mem_addr[i]      = a;
    endtask

    // Holder h drives its lock phase: 0 abort, 1 commit then release, 2 misaligned commit, 3 commit+release together.
    task automatic run_hold(int h, int mode, logic [31:0] d);
        mem_req_read[h] = 1'b0; mem_req_write[h] = 1'b0;
        if (mode != 0) begin mem_write_commit[h] = 1'b1; mem_wdata[h] = d; end
        if (mode == 2) mem_addr[h][1:0] = 2'b10;
        if (mode == 3) mem_release[h] = 1'b1;
        tick();
        clr_pulses();
        if (mode != 3) begin
            mem_release[h] = 1'b1;
            tick();
            clr_pulses();
        end
    endtask

    task automatic rand_cycle(bit viol);
        int j;
        clr_pulses();
        if (m_held) begin
            if (hold_ph == 0) plan = viol ? $urandom_range(0, 3) : $urandom_range(0, 1);
            mem_req_read[m_h] = 1'b0; mem_req_write[m_h] = 1'b0;
            case (plan)
                0: if (hold_ph == 1) mem_release[m_h] = 1'b1;
                1: begin
                    if (hold_ph == 0) begin mem_write_commit[m_h] = 1'b1; mem_wdata[m_h] = $urandom; end
                    else if (hold_ph == 2) mem_release[m_h] = 1'b1;
                end
                2: begin
                    if (hold_ph == 0) begin
                        mem_addr[m_h][1:0] = 2'($urandom_range(1, 3));
                        mem_write_commit[m_h] = 1'b1; mem_wdata[m_h] = $urandom;
                    end else if (hold_ph == 1) mem_release[m_h] = 1'b1;
                end
                default: if (hold_ph == 0) begin
                    mem_write_commit[m_h] = 1'b1; mem_release[m_h] = 1'b1; mem_wdata[m_h] = $urandom;
                end
            endcase
            if (viol && $urandom_range(0, 9) == 0) begin
                j = (m_h + $urandom_range(1, N - 1)) % N;
                if ($urandom_range(0, 1) == 1) mem_write_commit[j] = 1'b1;
                else mem_release[j] = 1'b1;
            end
            hold_ph++;
        end else begin
            hold_ph = 0;
            if ($urandom_range(0, 3) == 0) head_issue_id = IW'($urandom);
            for (int i = 0; i < N; i++)
                if (!mem_req_read[i] && !mem_req_write[i] && $urandom_range(0, 2) == 0)
                    request(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), rand_addr());
            if (viol && $urandom_range(0, 19) == 0) mem_write_commit[$urandom_range(0, N - 1)] = 1'b1;
        end
        tick();
    endtask

    initial begin
        head_issue_id = '0;
        clr_all();
        @(posedge clk);
        #1;
        // Reset state.
        tick(); tick();
        rst = 1'b0;
        tick();

        // Preload words 0..15 through aliasing addresses.
        for (int w = 0; w < 16; w++) begin
            request(w % N, 1'b1, w, {20'($urandom), 10'(w), 2'b00});
            tick();
            run_hold(w % N, 1, $urandom);
            tick();
        end

        // Store then load through another SIC.
        head_issue_id = '0;
        request(0, 1'b1, 2, 32'h10);
        tick();
        run_hold(0, 1, 32'hDEADBEEF);
        request(1, 1'b0, 3, 32'h10);
        tick();
        run_hold(1, 0, '0);
        tick();

        // Wrapped age order.
        head_issue_id = 4'd14;
        request(0, 1'b0, 1, 32'h20);
        request(1, 1'b0, 15, 32'h24);
        tick();
        run_hold(1, 0, '0);
        tick();
        run_hold(0, 1, 32'h1234_5678);
        tick();

        // Equal-age tie.
        head_issue_id = '0;
        request(1, 1'b0, 5, 32'h10);
        request(3, 1'b0, 5, 32'h14);
        tick();
        run_hold(1, 0, '0);
        tick();
        run_hold(3, 0, '0);
        tick();

        // Reset while SIC2 holds and keeps requesting.
        request(2, 1'b0, 4, 32'h08);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_hold(2, 0, '0);
        tick();

        // Violations, each from a clean reset.
        do_reset();
        request(0, 1'b1, 1, 32'h0C);
        tick();
        mem_write_commit[2] = 1'b1; mem_addr[2] = 32'h18; mem_wdata[2] = 32'hBAD0_0001;
        run_hold(0, 0, '0);
        tick();
        do_reset();
        request(1, 1'b1, 1, 32'h1C);
        tick();
        run_hold(1, 2, 32'hBAD0_0002);
        tick();
        do_reset();
        request(0, 1'b1, 1, 32'h28);
        tick();
        mem_release[3] = 1'b1;
        run_hold(0, 1, 32'hC0DE_0003);
        tick();
        do_reset();
        request(2, 1'b1, 1, 32'h2C);
        tick();
        run_hold(2, 3, 32'hC0DE_0004);
        tick();

        // Randomized traffic: clean first, then with violations.
        do_reset();
        for (int k = 0; k < 400; k++) rand_cycle(1'b0);
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 60; k++) rand_cycle(1'b1);
        end

        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected snapshots never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
